// File: rtl/audio_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : audio_pkg
// Brief    : Shared widths, frame-counter bit map and slot limits for the
//            I2S Pmod audio path.
// Revision : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int CNT_W    = 10;
    localparam int SLOT_W   = 5;
    localparam int IDX_W    = $clog2(SAMPLE_W);

    localparam int MCLK_BIT = 1;
    localparam int SCK_BIT  = 3;
    localparam int LRCK_BIT = 9;
    localparam int SLOT_HI  = 8;
    localparam int SLOT_LO  = 4;

    localparam logic [CNT_W-1:0]  FRAME_LAST = 10'd1023;
    localparam logic [SLOT_W-1:0] MSB_SLOT   = 5'd1;
    localparam logic [SLOT_W-1:0] LSB_SLOT   = 5'd16;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_e;

endpackage
`default_nettype wire

// File: rtl/audio_clk_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : audio_clk_gen
// Brief    : Free-running frame counter producing registered I2S clocks and
//            the next-cycle slot/channel decode for data serializers.
// Revision : 1.0 - initial release
// ============================================================================
module audio_clk_gen
    import audio_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic              mclk,
    output logic              sck,
    output logic              lrck,
    output logic              frame_end,
    output logic [SLOT_W-1:0] slot_next,
    output channel_e          chan_next
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_mclk;
    logic             r_sck;
    logic             r_lrck;
    logic             r_frame_end;

    // Every output is decoded from the value the counter is about to take,
    // so clocks and data all move on the same edge as the counter.
    assign w_cnt_next = r_cnt + CNT_W'(1);
    assign slot_next  = w_cnt_next[SLOT_HI:SLOT_LO];
    assign chan_next  = channel_e'(w_cnt_next[LRCK_BIT]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_mclk      <= 1'b0;
            r_sck       <= 1'b0;
            r_lrck      <= 1'b0;
            r_frame_end <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_mclk      <= w_cnt_next[MCLK_BIT];
            r_sck       <= w_cnt_next[SCK_BIT];
            r_lrck      <= w_cnt_next[LRCK_BIT];
            r_frame_end <= (w_cnt_next == FRAME_LAST);
        end
    end

    assign mclk      = r_mclk;
    assign sck       = r_sck;
    assign lrck      = r_lrck;
    assign frame_end = r_frame_end;

endmodule
`default_nettype wire

// File: rtl/speaker_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : speaker_serializer
// Brief    : Accepts one left/right sample pair per frame and serializes it
//            MSB first, I2S-aligned, onto the Pmod DAC pins.
// Revision : 1.0 - initial release
// ============================================================================
module speaker_serializer
    import audio_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] audio_left,
    input  logic [SAMPLE_W-1:0] audio_right,
    input  logic                sample_valid,
    input  logic                mute,
    output logic                sample_ready,
    output logic                underrun,
    output logic                audio_mclk,
    output logic                audio_sck,
    output logic                audio_lrck,
    output logic                audio_sdin
);

    logic                w_mclk;
    logic                w_sck;
    logic                w_lrck;
    logic                w_frame_end;
    logic [SLOT_W-1:0]   w_slot_next;
    channel_e            w_chan_next;

    logic [SAMPLE_W-1:0] r_shl;
    logic [SAMPLE_W-1:0] r_shr;
    logic [SAMPLE_W-1:0] w_sel;
    logic [IDX_W-1:0]    w_idx;
    logic                w_in_word;
    logic                w_bit;
    logic                r_sdin;

    audio_clk_gen u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .mclk      (w_mclk),
        .sck       (w_sck),
        .lrck      (w_lrck),
        .frame_end (w_frame_end),
        .slot_next (w_slot_next),
        .chan_next (w_chan_next)
    );

    // Slot 0 is the one-bit I2S delay; slots past the LSB pad with zeros.
    assign w_sel     = (w_chan_next == CH_RIGHT) ? r_shr : r_shl;
    assign w_in_word = (w_slot_next >= MSB_SLOT) && (w_slot_next <= LSB_SLOT);
    assign w_idx     = IDX_W'(LSB_SLOT - w_slot_next);
    assign w_bit     = w_in_word & w_sel[w_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shl  <= '0;
            r_shr  <= '0;
            r_sdin <= 1'b0;
        end else begin
            r_sdin <= w_bit;
            if (w_frame_end) begin
                if (mute) begin
                    r_shl <= '0;
                    r_shr <= '0;
                end else if (sample_valid) begin
                    r_shl <= audio_left;
                    r_shr <= audio_right;
                end
            end
        end
    end

    // Underrun must flag the boundary cycle itself, so it is the registered
    // boundary strobe qualified by the handshake inputs of that cycle.
    assign sample_ready = w_frame_end;
    assign underrun     = w_frame_end & ~sample_valid & ~mute;
    assign audio_mclk   = w_mclk;
    assign audio_sck    = w_sck;
    assign audio_lrck   = w_lrck;
    assign audio_sdin   = r_sdin;

endmodule
`default_nettype wire

// File: tb/tb_speaker_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_speaker_serializer
// Brief    : Scoreboard bench: frames are queued at each handshake and a
//            monitor compares the 64 bits captured at SCK rises per frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_speaker_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] audio_left = '0;
    logic [15:0] audio_right = '0;
    logic        sample_valid = 1'b0;
    logic        mute = 1'b0;
    logic        sample_ready;
    logic        underrun;
    logic        audio_mclk;
    logic        audio_sck;
    logic        audio_lrck;
    logic        audio_sdin;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [31:0] tb_cyc;
    logic [15:0] last_l = '0;
    logic [15:0] last_r = '0;

    always #5 clk = ~clk;

    speaker_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .audio_left   (audio_left),
        .audio_right  (audio_right),
        .sample_valid (sample_valid),
        .mute         (mute),
        .sample_ready (sample_ready),
        .underrun     (underrun),
        .audio_mclk   (audio_mclk),
        .audio_sck    (audio_sck),
        .audio_lrck   (audio_lrck),
        .audio_sdin   (audio_sdin)
    );

    // Reference count of clk edges since the last reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_cyc <= '0;
        else      tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_ready"}, sample_ready, 1'b0);
        chk1({tag, "_underrun"}, underrun, 1'b0);
        chk1({tag, "_mclk"}, audio_mclk, 1'b0);
        chk1({tag, "_sck"}, audio_sck, 1'b0);
        chk1({tag, "_lrck"}, audio_lrck, 1'b0);
        chk1({tag, "_sdin"}, audio_sdin, 1'b0);
    endtask

    // Clock waveforms, boundary strobe and SDIN edge placement.
    logic prev_sdin = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            chk1("mclk", audio_mclk, tb_cyc[1]);
            chk1("sck", audio_sck, tb_cyc[3]);
            chk1("lrck", audio_lrck, tb_cyc[9]);
            chk1("ready", sample_ready, tb_cyc[9:0] == 10'd1023);
            chk1("sdin_moved_off_sck_fall",
                 (audio_sdin !== prev_sdin) && (tb_cyc[3:0] != 4'd0), 1'b0);
            prev_sdin = audio_sdin;
        end else begin
            prev_sdin = 1'b0;
        end
    end

    // Monitor: one bit per SCK rise, 64 bits per frame, compared to the queue.
    logic        prev_sck = 1'b0;
    int          bitcnt = 0;
    logic [63:0] frame_bits = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_sck   = 1'b0;
            bitcnt     = 0;
            frame_bits = '0;
        end else begin
            if (audio_sck && !prev_sck) begin
                frame_bits = {frame_bits[62:0], audio_sdin};
                bitcnt++;
                if (bitcnt == 64) begin
                    bitcnt = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL frame: got %h, expected nothing queued", frame_bits);
                    end else begin
                        chk64("frame", frame_bits, exp_q.pop_front());
                    end
                end
            end
            prev_sck = audio_sck;
        end
    end

    task automatic send(input logic v, input logic m, input logic [15:0] l, input logic [15:0] r);
        int k;
        sample_valid = v;
        mute         = m;
        audio_left   = l;
        audio_right  = r;
        k = 0;
        while (sample_ready !== 1'b1 && k < 1100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1100) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got no sample_ready, expected one within 1100 cycles");
            return;
        end
        chk1("underrun_at_boundary", underrun, !v && !m);
        if (m) begin
            last_l = '0;
            last_r = '0;
        end else if (v) begin
            last_l = l;
            last_r = r;
        end
        exp_q.push_back({1'b0, last_l, 15'd0, 1'b0, last_r, 15'd0});
        @(negedge clk);
        chk1("ready_one_cycle", sample_ready, 1'b0);
        chk1("underrun_one_cycle", underrun, 1'b0);
        // Mid-frame garbage on the inputs must not reach the shadow registers.
        audio_left   = 16'($urandom);
        audio_right  = 16'($urandom);
        sample_valid = 1'($urandom);
        mute         = 1'($urandom);
    endtask

    initial begin
        int k;
        exp_q.push_back(64'd0);
        repeat (5) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        send(1'b1, 1'b0, 16'hB000, 16'h5FFF);
        send(1'b1, 1'b0, 16'h1234, 16'h4321);
        send(1'b0, 1'b0, 16'hDEAD, 16'hBEEF);
        send(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        send(1'b0, 1'b1, 16'hAAAA, 16'h5555);
        send(1'b1, 1'b0, 16'h8001, 16'h7FFE);
        for (int i = 0; i < 30; i++)
            send(1'b1, 1'b0, 16'($urandom), 16'($urandom));

        k = 0;
        while (tb_cyc[9:0] != 10'd300 && k < 1100) begin
            @(negedge clk);
            k++;
        end
        chk1("reached_cnt_300", tb_cyc[9:0] == 10'd300, 1'b1);
        rst = 1'b0;
        #1;
        chk_all_zero("midframe_reset");
        exp_q.delete();
        exp_q.push_back(64'd0);
        last_l = '0;
        last_r = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("held_reset");
        rst = 1'b1;

        send(1'b1, 1'b0, 16'h8000, 16'h0001);
        k = 0;
        while (audio_sdin !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk64("left_msb_latency", 64'(tb_cyc), 64'd1040);

        send(1'b1, 1'b0, 16'hC3A5, 16'h0F0F);
        k = 0;
        while (exp_q.size() != 0 && k < 1100) begin
            @(negedge clk);
            k++;
        end
        chk64("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
